// File: rtl/slc3_datapath.sv
// SLC-3 datapath: architectural registers, register file, ALU, address adder and the shared bus,
// steered cycle-by-cycle by the ISDU control word.
module slc3_datapath #(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              LD_IR,
   input  logic              LD_BEN,
   input  logic              LD_CC,
   input  logic              LD_REG,
   input  logic              LD_PC,
   input  logic              GatePC,
   input  logic              GateMDR,
   input  logic              GateALU,
   input  logic              GateMARMUX,
   input  logic [1:0]        PCMUX,
   input  logic [1:0]        ADDR2MUX,
   input  logic [1:0]        ALUK,
   input  logic              ADDR1MUX,
   input  logic              MARMUX,
   input  logic              SR2MUX,
   input  logic              DRMUX,
   input  logic              SR1MUX,
   input  logic              MIO_EN,
   input  logic [DATA_W-1:0] Data_from_mem,
   output logic [DATA_W-1:0] BUS,
   output logic [DATA_W-1:0] PC,
   output logic [DATA_W-1:0] IR,
   output logic [DATA_W-1:0] MAR,
   output logic [DATA_W-1:0] MDR,
   output logic [2:0]        nzp,
   output logic              BEN,
   output logic              bus_conflict,
   output logic              conflict_sticky
);

   logic [DATA_W-1:0] regs [8];
   logic [2:0]        sr1, sr2, dr;
   logic [DATA_W-1:0] sr1_out, sr2_out, alu_b, alu_out;
   logic [DATA_W-1:0] addr1, addr2, addr_sum, marmux_out;
   logic [2:0]        nzp_next;

   function automatic logic [DATA_W-1:0] sext5(input logic [4:0] x);
      return {{(DATA_W-5){x[4]}}, x};
   endfunction

   function automatic logic [DATA_W-1:0] sext6(input logic [5:0] x);
      return {{(DATA_W-6){x[5]}}, x};
   endfunction

   function automatic logic [DATA_W-1:0] sext9(input logic [8:0] x);
      return {{(DATA_W-9){x[8]}}, x};
   endfunction

   function automatic logic [DATA_W-1:0] sext11(input logic [10:0] x);
      return {{(DATA_W-11){x[10]}}, x};
   endfunction

   assign sr1     = SR1MUX ? IR[8:6] : IR[11:9];
   assign sr2     = IR[2:0];
   assign dr      = DRMUX ? 3'd7 : IR[11:9];
   assign sr1_out = regs[sr1];
   assign sr2_out = regs[sr2];
   assign alu_b   = SR2MUX ? sext5(IR[4:0]) : sr2_out;

   always_comb begin
      unique case (ALUK)
         2'b00:   alu_out = sr1_out + alu_b;
         2'b01:   alu_out = sr1_out & alu_b;
         2'b10:   alu_out = ~sr1_out;
         default: alu_out = sr1_out;
      endcase
   end

   assign addr1 = ADDR1MUX ? sr1_out : PC;

   always_comb begin
      unique case (ADDR2MUX)
         2'b00:   addr2 = '0;
         2'b01:   addr2 = sext6(IR[5:0]);
         2'b10:   addr2 = sext9(IR[8:0]);
         default: addr2 = sext11(IR[10:0]);
      endcase
   end

   assign addr_sum   = addr1 + addr2;
   assign marmux_out = MARMUX ? addr_sum : {{(DATA_W-8){1'b0}}, IR[7:0]};

   // Fixed priority keeps BUS defined even when the control word is illegal.
   always_comb begin
      if (GatePC)          BUS = PC;
      else if (GateMDR)    BUS = MDR;
      else if (GateALU)    BUS = alu_out;
      else if (GateMARMUX) BUS = marmux_out;
      else                 BUS = '0;
   end

   assign bus_conflict = (GatePC  & (GateMDR | GateALU | GateMARMUX)) |
                         (GateMDR & (GateALU | GateMARMUX)) |
                         (GateALU & GateMARMUX);

   assign nzp_next = BUS[DATA_W-1] ? 3'b100 : ((BUS == '0) ? 3'b010 : 3'b001);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (LD_REG) begin
         regs[dr] <= BUS;
      end
   end

   // BEN deliberately samples the pre-edge IR and nzp, so it may share a cycle with LD_IR/LD_CC.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         PC              <= RESET_PC;
         IR              <= '0;
         MAR             <= '0;
         MDR             <= '0;
         nzp             <= 3'b010;
         BEN             <= 1'b0;
         conflict_sticky <= 1'b0;
      end else begin
         if (LD_PC) begin
            unique case (PCMUX)
               2'b00:   PC <= PC + DATA_W'(1);
               2'b01:   PC <= BUS;
               2'b10:   PC <= addr_sum;
               default: PC <= PC;
            endcase
         end
         if (LD_IR)        IR              <= BUS;
         if (LD_MAR)       MAR             <= BUS;
         if (LD_MDR)       MDR             <= MIO_EN ? Data_from_mem : BUS;
         if (LD_CC)        nzp             <= nzp_next;
         if (LD_BEN)       BEN             <= |(IR[11:9] & nzp);
         if (bus_conflict) conflict_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_slc3_datapath.sv
// Bench for slc3_datapath: directed scenarios then randomized control words against a reference model.
module tb_slc3_datapath;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
   logic        GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0]  PCMUX, ADDR2MUX, ALUK;
   logic        ADDR1MUX, MARMUX, SR2MUX, DRMUX, SR1MUX, MIO_EN;
   logic [15:0] Data_from_mem;
   logic [15:0] BUS, PC, IR, MAR, MDR;
   logic [2:0]  nzp;
   logic        BEN, bus_conflict, conflict_sticky;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [15:0] m_pc, m_ir, m_mar, m_mdr;
   logic [15:0] m_r [8];
   logic [2:0]  m_nzp;
   logic        m_ben, m_sticky;

   slc3_datapath #(.DATA_W(16), .RESET_PC(16'h3000)) dut (
      .Clk(Clk), .Reset(Reset),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .ADDR1MUX(ADDR1MUX), .MARMUX(MARMUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
      .MIO_EN(MIO_EN), .Data_from_mem(Data_from_mem),
      .BUS(BUS), .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR),
      .nzp(nzp), .BEN(BEN), .bus_conflict(bus_conflict), .conflict_sticky(conflict_sticky)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
      int t;
      t = int'(v) % (1 << bits);
      if (t >= (1 << (bits - 1))) t -= (1 << bits);
      return 16'(t);
   endfunction

   task automatic clr();
      {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC} = '0;
      {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
      PCMUX = 2'd0; ADDR2MUX = 2'd0; ALUK = 2'd0;
      {ADDR1MUX, MARMUX, SR2MUX, DRMUX, SR1MUX, MIO_EN} = '0;
      Data_from_mem = 16'h0;
   endtask

   // Called just after a posedge with inputs applied; checks the bus, clocks once, checks state.
   task automatic cycle();
      logic [15:0] a, bb, alu, a1, a2, sum, mm, b;
      logic [2:0]  s1, d, cc;
      logic        c, nb;
      int          ng;
      s1 = SR1MUX ? m_ir[8:6] : m_ir[11:9];
      d  = DRMUX ? 3'd7 : m_ir[11:9];
      a  = m_r[s1];
      bb = SR2MUX ? sx(m_ir, 5) : m_r[m_ir[2:0]];
      case (ALUK)
         2'd0:    alu = 16'(int'(a) + int'(bb));
         2'd1:    alu = a & bb;
         2'd2:    alu = 16'(65535 - int'(a));
         default: alu = a;
      endcase
      a1 = ADDR1MUX ? a : m_pc;
      case (ADDR2MUX)
         2'd0:    a2 = 16'h0;
         2'd1:    a2 = sx(m_ir, 6);
         2'd2:    a2 = sx(m_ir, 9);
         default: a2 = sx(m_ir, 11);
      endcase
      sum = 16'((int'(a1) + int'(a2)) % 65536);
      mm  = MARMUX ? sum : 16'(int'(m_ir) % 256);
      ng  = int'(GatePC) + int'(GateMDR) + int'(GateALU) + int'(GateMARMUX);
      c   = (ng > 1);
      if (GatePC)          b = m_pc;
      else if (GateMDR)    b = m_mdr;
      else if (GateALU)    b = alu;
      else if (GateMARMUX) b = mm;
      else                 b = 16'h0;
      cc = (b >= 16'h8000) ? 3'b100 : ((b == 16'h0) ? 3'b010 : 3'b001);
      nb = ((m_ir[11] && m_nzp[2]) || (m_ir[10] && m_nzp[1]) || (m_ir[9] && m_nzp[0]));
      #3;
      chk("bus", BUS, b);
      chk("bus_conflict", 16'(bus_conflict), 16'(c));
      @(posedge Clk);
      if (Reset) begin
         m_pc = 16'h3000; m_ir = 0; m_mar = 0; m_mdr = 0;
         for (int i = 0; i < 8; i++) m_r[i] = 0;
         m_nzp = 3'b010; m_ben = 0; m_sticky = 0;
      end else begin
         if (LD_BEN) m_ben = nb;
         if (LD_REG) m_r[d] = b;
         if (LD_PC) begin
            if (PCMUX == 2'd0)      m_pc = 16'((int'(m_pc) + 1) % 65536);
            else if (PCMUX == 2'd1) m_pc = b;
            else if (PCMUX == 2'd2) m_pc = sum;
         end
         if (LD_IR)  m_ir  = b;
         if (LD_MAR) m_mar = b;
         if (LD_MDR) m_mdr = MIO_EN ? Data_from_mem : b;
         if (LD_CC)  m_nzp = cc;
         if (c)      m_sticky = 1;
      end
      #1;
      chk("pc", PC, m_pc);
      chk("ir", IR, m_ir);
      chk("mar", MAR, m_mar);
      chk("mdr", MDR, m_mdr);
      chk("nzp", 16'(nzp), 16'(m_nzp));
      chk("ben", 16'(BEN), 16'(m_ben));
      chk("sticky", 16'(conflict_sticky), 16'(m_sticky));
   endtask

   task automatic load_mdr(input logic [15:0] v);
      clr(); MIO_EN = 1; Data_from_mem = v; LD_MDR = 1; cycle();
   endtask

   task automatic load_ir(input logic [15:0] v);
      load_mdr(v);
      clr(); GateMDR = 1; LD_IR = 1; cycle();
   endtask

   task automatic set_reg(input int r, input logic [15:0] v);
      load_ir(16'(r << 9));
      load_mdr(v);
      clr(); GateMDR = 1; LD_REG = 1; cycle();
   endtask

   initial begin
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_nzp = 0; m_ben = 0; m_sticky = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      clr();
      Reset = 1;
      @(posedge Clk); #1;
      cycle();
      Reset = 0;
      clr(); #2;
      chk("reset_pc", PC, 16'h3000);
      chk("reset_nzp", 16'(nzp), 16'h0002);
      chk("idle_bus", BUS, 16'h0000);
      chk("reset_ir", IR, 16'h0000);
      chk("reset_sticky", 16'(conflict_sticky), 16'h0000);
      @(posedge Clk); #1;

      // R3 = 0x00FF through the MARMUX zero-extend path
      load_ir(16'h06FF);
      clr(); GateMARMUX = 1; MARMUX = 0; LD_REG = 1; cycle();
      clr(); load_ir(16'h0600);
      clr(); GateALU = 1; ALUK = 2'd3; #2;
      chk("r3_read", BUS, 16'h00FF);
      cycle();

      clr(); LD_PC = 1; PCMUX = 2'd0; cycle();
      chk("pc_inc", PC, 16'h3001);

      // ADD R1,R2,R3 with overflow into the sign bit
      set_reg(2, 16'h7FFF);
      set_reg(3, 16'h0001);
      load_ir(16'h1283);
      clr(); GateALU = 1; LD_REG = 1; LD_CC = 1; SR1MUX = 1; ALUK = 2'd0; #2;
      chk("add_bus", BUS, 16'h8000);
      cycle();
      chk("add_nzp", 16'(nzp), 16'h0004);
      load_ir(16'h0200);
      clr(); GateALU = 1; ALUK = 2'd3; #2;
      chk("r1_read", BUS, 16'h8000);
      cycle();

      // BRnp taken, then PC-relative target
      load_ir(16'h0A05);
      clr(); GateMDR = 1; LD_CC = 1; cycle();
      chk("br_nzp", 16'(nzp), 16'h0001);
      clr(); LD_BEN = 1; cycle();
      chk("br_ben", 16'(BEN), 16'h0001);
      clr(); LD_PC = 1; PCMUX = 2'd2; ADDR1MUX = 0; ADDR2MUX = 2'd2; cycle();
      chk("br_pc", PC, 16'h3006);

      // memory read into MDR then IR
      load_mdr(16'h4000);
      clr(); GateMDR = 1; LD_MAR = 1; cycle();
      chk("mar", MAR, 16'h4000);
      load_mdr(16'hBEEF);
      chk("mdr_mem", MDR, 16'hBEEF);
      clr(); GateMDR = 1; LD_IR = 1; cycle();
      chk("ir_mem", IR, 16'hBEEF);

      // PC wrap and hold
      load_mdr(16'hFFFF);
      clr(); GateMDR = 1; LD_PC = 1; PCMUX = 2'd1; cycle();
      chk("pc_ffff", PC, 16'hFFFF);
      clr(); LD_PC = 1; PCMUX = 2'd0; cycle();
      chk("pc_wrap", PC, 16'h0000);
      clr(); LD_PC = 1; PCMUX = 2'd3; cycle();
      chk("pc_hold", PC, 16'h0000);

      // bus contention
      clr(); LD_PC = 1; PCMUX = 2'd0; cycle();
      clr(); GatePC = 1; GateALU = 1; #2;
      chk("conf_bus", BUS, 16'h0001);
      chk("conf_flag", 16'(bus_conflict), 16'h0001);
      cycle();
      clr();
      for (int i = 0; i < 3; i++) cycle();
      chk("conf_sticky", 16'(conflict_sticky), 16'h0001);
      Reset = 1; cycle(); Reset = 0;
      chk("sticky_clr", 16'(conflict_sticky), 16'h0000);

      // randomized control words
      for (int n = 0; n < 800; n++) begin
         Reset      = ($urandom_range(0, 39) == 0);
         LD_MAR     = $urandom_range(0, 1);
         LD_MDR     = $urandom_range(0, 1);
         LD_IR      = ($urandom_range(0, 2) == 0);
         LD_BEN     = $urandom_range(0, 1);
         LD_CC      = $urandom_range(0, 1);
         LD_REG     = $urandom_range(0, 1);
         LD_PC      = ($urandom_range(0, 2) == 0);
         GatePC     = ($urandom_range(0, 4) == 0);
         GateMDR    = ($urandom_range(0, 3) == 0);
         GateALU    = ($urandom_range(0, 2) == 0);
         GateMARMUX = ($urandom_range(0, 3) == 0);
         PCMUX      = 2'($urandom_range(0, 3));
         ADDR2MUX   = 2'($urandom_range(0, 3));
         ALUK       = 2'($urandom_range(0, 3));
         ADDR1MUX   = $urandom_range(0, 1);
         MARMUX     = $urandom_range(0, 1);
         SR2MUX     = $urandom_range(0, 1);
         DRMUX      = $urandom_range(0, 1);
         SR1MUX     = $urandom_range(0, 1);
         MIO_EN     = $urandom_range(0, 1);
         Data_from_mem = 16'($urandom);
         cycle();
      end
      Reset = 0;
      clr();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
